// File: rtl/mux_unstriping.sv
`default_nettype none
// ============================================================================
// Module   : mux_unstriping
// Purpose  : Merges two striped lanes back into one word stream (lane 0 first).
//            Per-lane FIFOs absorb skew. Sticky overflow and skew flags.
// Revision : 1.0 - initial release
// ============================================================================
module mux_unstriping #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 2
) (
    input  logic                       clk_2f,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           lane_0,
    input  logic                       valid_in0,
    input  logic [WIDTH-1:0]           lane_1,
    input  logic                       valid_in1,
    input  logic                       flush,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic                       err_overflow,
    output logic                       err_skew,
    output logic [$clog2(DEPTH+1)-1:0] level0,
    output logic [$clog2(DEPTH+1)-1:0] level1
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [AW-1:0]    wp0_q, rp0_q, wp1_q, rp1_q;
    logic [AW-1:0]    wp0_d, rp0_d, wp1_d, rp1_d;
    logic [LW-1:0]    lvl0_q, lvl1_q, lvl0_d, lvl1_d;
    logic             rd_sel_q, rd_sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             skew_q, skew_d;

    logic             pop0, pop1, push0, push1, full0, full1, drop;
    logic [LW-1:0]    diff;

    // Pop decisions use registered levels only, so a same-cycle push is never bypassed.
    always_comb begin
        pop0  = !rd_sel_q && (lvl0_q != '0);
        pop1  =  rd_sel_q && (lvl1_q != '0);
        full0 = (lvl0_q == LW'(DEPTH));
        full1 = (lvl1_q == LW'(DEPTH));
        push0 = valid_in0 && (!full0 || pop0);
        push1 = valid_in1 && (!full1 || pop1);
        drop  = (valid_in0 && full0 && !pop0) || (valid_in1 && full1 && !pop1);
        diff  = (lvl0_q > lvl1_q) ? (lvl0_q - lvl1_q) : (lvl1_q - lvl0_q);
    end

    always_comb begin
        wp0_d    = push0 ? wp0_q + AW'(1) : wp0_q;
        wp1_d    = push1 ? wp1_q + AW'(1) : wp1_q;
        rp0_d    = pop0  ? rp0_q + AW'(1) : rp0_q;
        rp1_d    = pop1  ? rp1_q + AW'(1) : rp1_q;
        lvl0_d   = lvl0_q + LW'(push0) - LW'(pop0);
        lvl1_d   = lvl1_q + LW'(push1) - LW'(pop1);
        rd_sel_d = (pop0 || pop1) ? !rd_sel_q : rd_sel_q;
        valid_d  = pop0 || pop1;
        data_d   = data_q;
        if (pop0) begin
            data_d = mem0_q[rp0_q];
        end else if (pop1) begin
            data_d = mem1_q[rp1_q];
        end
        ovf_d    = ovf_q || drop;
        skew_d   = skew_q || (diff > LW'(MAX_SKEW));
    end

    always_ff @(posedge clk_2f) begin
        if (push0 && !flush) begin
            mem0_q[wp0_q] <= lane_0;
        end
        if (push1 && !flush) begin
            mem1_q[wp1_q] <= lane_1;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            wp0_q    <= '0;
            wp1_q    <= '0;
            rp0_q    <= '0;
            rp1_q    <= '0;
            lvl0_q   <= '0;
            lvl1_q   <= '0;
            rd_sel_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            skew_q   <= 1'b0;
        end else if (flush) begin
            wp0_q    <= '0;
            wp1_q    <= '0;
            rp0_q    <= '0;
            rp1_q    <= '0;
            lvl0_q   <= '0;
            lvl1_q   <= '0;
            rd_sel_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            skew_q   <= 1'b0;
        end else begin
            wp0_q    <= wp0_d;
            wp1_q    <= wp1_d;
            rp0_q    <= rp0_d;
            rp1_q    <= rp1_d;
            lvl0_q   <= lvl0_d;
            lvl1_q   <= lvl1_d;
            rd_sel_q <= rd_sel_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            skew_q   <= skew_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign err_overflow = ovf_q;
    assign err_skew     = skew_q;
    assign level0       = lvl0_q;
    assign level1       = lvl1_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_unstriping.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_unstriping
// Purpose  : Directed self-checking bench for mux_unstriping (WIDTH=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_unstriping;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic [31:0] lane_0, lane_1;
    logic        valid_in0, valid_in1, flush;
    logic [31:0] data_out;
    logic        valid_out, err_overflow, err_skew;
    logic [2:0]  level0, level1;

    int checks = 0;
    int errors = 0;

    mux_unstriping #(.WIDTH(32), .DEPTH(4), .MAX_SKEW(2)) dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .lane_0       (lane_0),
        .valid_in0    (valid_in0),
        .lane_1       (lane_1),
        .valid_in1    (valid_in1),
        .flush        (flush),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .err_overflow (err_overflow),
        .err_skew     (err_skew),
        .level0       (level0),
        .level1       (level1)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic tick();
        @(posedge clk_2f);
        @(negedge clk_2f);
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        valid_in0 = v0;
        lane_0    = d0;
        valid_in1 = v1;
        lane_1    = d1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        checks++;
        if (data_out !== 32'h0 || valid_out !== 1'b0 || err_overflow !== 1'b0 ||
            err_skew !== 1'b0 || level0 !== 3'd0 || level1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_state data=%h v=%b ovf=%b skew=%b l0=%0d l1=%0d required all 0",
                     data_out, valid_out, err_overflow, err_skew, level0, level1);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_in_order();
        drive(1'b1, 32'hA000_0000, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL order_no_bypass valid=%b required 0", valid_out);
        end
        drive(1'b0, 32'h0, 1'b1, 32'hB000_0001);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hA000_0000) begin
            errors++; $display("FAIL order_A0 data=%h v=%b required A0000000/1", data_out, valid_out);
        end
        drive(1'b1, 32'hA000_0002, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hB000_0001) begin
            errors++; $display("FAIL order_B1 data=%h v=%b required B0000001/1", data_out, valid_out);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hA000_0002) begin
            errors++; $display("FAIL order_A2 data=%h v=%b required A0000002/1", data_out, valid_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'hA000_0002) begin
            errors++; $display("FAIL order_hold data=%h v=%b required A0000002/0", data_out, valid_out);
        end
    endtask

    task automatic test_skew();
        do_flush();
        drive(1'b1, 32'hA0, 1'b0, 32'h0);        // E0
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);         // E1
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hA0) begin
            errors++; $display("FAIL skew_A0 data=%h v=%b required a0/1", data_out, valid_out);
        end
        drive(1'b1, 32'hA2, 1'b0, 32'h0);        // E2
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL skew_stall1 v=%b required 0", valid_out);
        end
        drive(1'b0, 32'h0, 1'b1, 32'hB1);        // E3
        tick();
        checks++;
        if (valid_out !== 1'b0 || level0 !== 3'd1 || level1 !== 3'd1) begin
            errors++; $display("FAIL skew_stall2 v=%b l0=%0d l1=%0d required 0/1/1", valid_out, level0, level1);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);         // E4
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hB1) begin
            errors++; $display("FAIL skew_B1 data=%h v=%b required b1/1", data_out, valid_out);
        end
        drive(1'b0, 32'h0, 1'b1, 32'hB3);        // E5
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hA2) begin
            errors++; $display("FAIL skew_A2 data=%h v=%b required a2/1", data_out, valid_out);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);         // E6
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hB3 || err_skew !== 1'b0) begin
            errors++; $display("FAIL skew_B3 data=%h v=%b skew=%b required b3/1/0", data_out, valid_out, err_skew);
        end
    endtask

    task automatic test_overflow();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i));
            tick();
        end
        checks++;
        if (level1 !== 3'd4 || err_overflow !== 1'b0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL ovf_fill l1=%0d ovf=%b v=%b required 4/0/0", level1, err_overflow, valid_out);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h104);
        tick();
        checks++;
        if (level1 !== 3'd4 || err_overflow !== 1'b1 || err_skew !== 1'b1 || valid_out !== 1'b0) begin
            errors++; $display("FAIL ovf_drop l1=%0d ovf=%b skew=%b v=%b required 4/1/1/0",
                               level1, err_overflow, err_skew, valid_out);
        end
        drive(1'b1, 32'hC0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hC0) begin
            errors++; $display("FAIL ovf_L0 data=%h v=%b required c0/1", data_out, valid_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h100 || level1 !== 3'd3) begin
            errors++; $display("FAIL ovf_L1_0 data=%h v=%b l1=%0d required 100/1/3", data_out, valid_out, level1);
        end
        drive(1'b1, 32'hC1, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL ovf_wait_l0 v=%b required 0", valid_out);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h101) begin
            errors++; $display("FAIL ovf_L1_1 data=%h v=%b required 101/1", data_out, valid_out);
        end
    endtask

    task automatic test_full_boundary();
        do_flush();
        drive(1'b1, 32'hD0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'hD1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'hD2, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'hD3, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'hD4, 1'b0, 32'h0);
        tick();
        checks++;
        if (level0 !== 3'd4 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL full_fill l0=%0d ovf=%b required 4/0", level0, err_overflow);
        end
        drive(1'b0, 32'h0, 1'b1, 32'hF1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hF1 || level0 !== 3'd4) begin
            errors++; $display("FAIL full_lane1 data=%h v=%b l0=%0d required f1/1/4", data_out, valid_out, level0);
        end
        drive(1'b1, 32'hD5, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hD1 || level0 !== 3'd4 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL full_pushpop data=%h v=%b l0=%0d ovf=%b required d1/1/4/0",
                               data_out, valid_out, level0, err_overflow);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hEE, 1'b1, 32'hF2);
        tick();
        checks++;
        if (err_overflow !== 1'b1 || err_skew !== 1'b1 || level0 !== 3'd4 || level1 !== 3'd1) begin
            errors++; $display("FAIL flush_pre ovf=%b skew=%b l0=%0d l1=%0d required 1/1/4/1",
                               err_overflow, err_skew, level0, level1);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h99, 1'b1, 32'h98);
        do_flush();
        checks++;
        if (level0 !== 3'd0 || level1 !== 3'd0 || err_overflow !== 1'b0 || err_skew !== 1'b0 ||
            valid_out !== 1'b0 || data_out !== 32'h0) begin
            errors++; $display("FAIL flush_clear l0=%0d l1=%0d ovf=%b skew=%b v=%b data=%h required all 0",
                               level0, level1, err_overflow, err_skew, valid_out, data_out);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h51);
        tick();
        drive(1'b1, 32'h50, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b0 || level1 !== 3'd1) begin
            errors++; $display("FAIL flush_lane0_first v=%b l1=%0d required 0/1", valid_out, level1);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h50) begin
            errors++; $display("FAIL flush_restart data=%h v=%b required 50/1", data_out, valid_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h51) begin
            errors++; $display("FAIL flush_next data=%h v=%b required 51/1", data_out, valid_out);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        drive(1'b1, 32'h70, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h71);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h70 || level1 !== 3'd1) begin
            errors++; $display("FAIL arst_pre data=%h v=%b l1=%0d required 70/1/1", data_out, valid_out, level1);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0 || level0 !== 3'd0 || level1 !== 3'd0) begin
            errors++; $display("FAIL arst_clear data=%h v=%b l0=%0d l1=%0d required 0/0/0/0",
                               data_out, valid_out, level0, level1);
        end
        #1 reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h81);
        tick();
        drive(1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL arst_wait v=%b required 0", valid_out);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h80) begin
            errors++; $display("FAIL arst_restart data=%h v=%b required 80/1", data_out, valid_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h81) begin
            errors++; $display("FAIL arst_next data=%h v=%b required 81/1", data_out, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_skew();
        test_overflow();
        test_full_boundary();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
